// File: rtl/armleocpu_divider_if.sv
// Request/response bundle between the execute stage and the iterative divider.
// The master raises a one-cycle valid with the operands; the slave answers with
// a one-cycle ready carrying quotient, remainder and the divide-by-zero flag.
interface armleocpu_divider_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             division_by_zero;

  modport master (
    output valid, is_signed, dividend, divisor,
    input  ready, quotient, remainder, division_by_zero
  );

  modport slave (
    input  valid, is_signed, dividend, divisor,
    output ready, quotient, remainder, division_by_zero
  );
endinterface

// File: rtl/armleocpu_divider.sv
// Iterative restoring divider producing one quotient bit per clock.
// Operands are reduced to magnitudes on capture, divided unsigned MSB first,
// and the signs are reapplied on the final iteration (RISC-V DIV/REM rules).
// A zero divisor short-circuits straight to DONE with the architectural result.
module armleocpu_divider #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  armleocpu_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    counter_q, counter_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  // The running remainder is always below the divisor magnitude, so it is
  // stored in WIDTH bits; the extra bit only exists in the combinational
  // shift/trial-subtract step where it is actually needed.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             a_neg;
  logic             b_neg;
  logic             last_iter;

  // State register: every flop of the divider, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign last_iter = (counter_q == CW'(WIDTH - 1));

  // Next-state logic: requests are only looked at in IDLE, so a valid that
  // arrives during CALC or DONE is simply dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.valid) begin
          state_d = (bus.divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, one restoring step per CALC cycle, and the
  // sign fix-up folded into the last step so results land as DONE begins.
  always_comb begin
    counter_d   = counter_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    shifted     = {rem_q, dvd_q[WIDTH-1]};
    trial       = shifted - {1'b0, dvs_q};
    a_neg       = bus.is_signed & bus.dividend[WIDTH-1];
    b_neg       = bus.is_signed & bus.divisor[WIDTH-1];

    case (state_q)
      IDLE: begin
        if (bus.valid) begin
          counter_d = '0;
          if (bus.divisor == '0) begin
            quotient_d  = '1;
            remainder_d = bus.dividend;
            dbz_d       = 1'b1;
          end else begin
            dvd_d   = a_neg ? -bus.dividend : bus.dividend;
            dvs_d   = b_neg ? -bus.divisor  : bus.divisor;
            neg_q_d = a_neg ^ b_neg;
            neg_r_d = a_neg;
            rem_d   = '0;
            quot_d  = '0;
            dbz_d   = 1'b0;
          end
        end
      end
      CALC: begin
        counter_d = counter_q + CW'(1);
        dvd_d     = {dvd_q[WIDTH-2:0], 1'b0};
        if (trial[WIDTH]) begin
          rem_d  = shifted[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_d  = trial[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], 1'b1};
        end
        if (last_iter) begin
          quotient_d  = neg_q_q ? -quot_d : quot_d;
          remainder_d = neg_r_q ? -rem_d  : rem_d;
        end
      end
      default: begin
      end
    endcase
  end

  // Outputs: ready is a pure decode of DONE; results come from holding registers.
  always_comb begin
    bus.ready            = (state_q == DONE);
    bus.quotient         = quotient_q;
    bus.remainder        = remainder_q;
    bus.division_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_armleocpu_divider.sv
// Self-checking bench for armleocpu_divider: a table of directed vectors with
// hand-computed results, plus hand-written sequences for ignored re-requests
// and a reset that aborts an operation in flight.
module tb_armleocpu_divider;

  localparam int WIDTH = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  armleocpu_divider_if #(.WIDTH(WIDTH)) dif ();

  armleocpu_divider #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expQ;
    logic [31:0] expR;
    logic        expDbz;
    logic [31:0] expLat;
  } vec_t;

  vec_t vecs [10];

  // Compare one observed value with its expected value and tally the result.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive a one-cycle valid pulse; returns at the falling edge after capture.
  task automatic pulseValid(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dif.valid     = 1'b1;
    dif.is_signed = sgn;
    dif.dividend  = a;
    dif.divisor   = b;
    @(negedge clk);
    dif.valid     = 1'b0;
  endtask

  // Issue a request and wait (bounded) for ready; lat counts cycles after valid.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                               output int lat);
    pulseValid(sgn, a, b);
    lat = 1;
    while (dif.ready !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int          lat;
    int          readys;
    logic [31:0] holdQ;
    logic [31:0] holdR;
    logic [31:0] gotQ;
    logic [31:0] gotR;

    checks        = 0;
    failures      = 0;
    rst_n         = 1'b1;
    dif.valid     = 1'b0;
    dif.is_signed = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        1'b0, 32'd33};
    vecs[1] = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 32'd33};
    vecs[2] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 32'd33};
    vecs[3] = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 32'd33};
    vecs[4] = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 32'd33};
    vecs[5] = '{1'b0, 32'd123,        32'd0,        32'hFFFFFFFF, 32'd123,      1'b1, 32'd1};
    vecs[6] = '{1'b1, 32'd123,        32'd0,        32'hFFFFFFFF, 32'd123,      1'b1, 32'd1};
    vecs[7] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 32'd33};
    vecs[8] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 32'd33};
    vecs[9] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 32'd33};

    repeat (3) @(negedge clk);
    checkOutput("reset_ready", {31'd0, dif.ready}, 32'd0);
    checkOutput("reset_quotient", dif.quotient, 32'd0);
    checkOutput("reset_remainder", dif.remainder, 32'd0);
    checkOutput("reset_dbz", {31'd0, dif.division_by_zero}, 32'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, lat);
      checkOutput($sformatf("v%0d_latency", i), 32'(lat), vecs[i].expLat);
      checkOutput($sformatf("v%0d_quotient", i), dif.quotient, vecs[i].expQ);
      checkOutput($sformatf("v%0d_remainder", i), dif.remainder, vecs[i].expR);
      checkOutput($sformatf("v%0d_dbz", i), {31'd0, dif.division_by_zero}, {31'd0, vecs[i].expDbz});
      holdQ = dif.quotient;
      holdR = dif.remainder;
      @(negedge clk);
      checkOutput($sformatf("v%0d_ready_drop", i), {31'd0, dif.ready}, 32'd0);
      checkOutput($sformatf("v%0d_hold_q", i), dif.quotient, vecs[i].expQ);
      checkOutput($sformatf("v%0d_hold_r", i), dif.remainder, vecs[i].expR);
      if (holdQ !== dif.quotient) begin
        checkOutput($sformatf("v%0d_hold_cmp", i), dif.quotient, holdQ);
      end
      repeat (2) @(negedge clk);
    end

    // A second request ten cycles into an operation must be ignored.
    pulseValid(1'b0, 32'd100, 32'd7);
    readys = 0;
    lat    = 0;
    gotQ   = '0;
    gotR   = '0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (dif.ready === 1'b1) begin
        readys++;
        lat  = cyc;
        gotQ = dif.quotient;
        gotR = dif.remainder;
      end
      if (cyc == 10) begin
        dif.valid    = 1'b1;
        dif.dividend = 32'd50;
        dif.divisor  = 32'd5;
      end else begin
        dif.valid = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput("repulse_ready_count", 32'(readys), 32'd1);
    checkOutput("repulse_latency", 32'(lat), 32'd33);
    checkOutput("repulse_quotient", gotQ, 32'd14);
    checkOutput("repulse_remainder", gotR, 32'd2);

    // Reset five cycles into an operation aborts it with no ready pulse.
    pulseValid(1'b0, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_ready", {31'd0, dif.ready}, 32'd0);
    checkOutput("abort_quotient", dif.quotient, 32'd0);
    checkOutput("abort_remainder", dif.remainder, 32'd0);
    checkOutput("abort_dbz", {31'd0, dif.division_by_zero}, 32'd0);
    rst_n  = 1'b0;
    readys = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (dif.ready === 1'b1) readys++;
    end
    checkOutput("abort_ready_count", 32'(readys), 32'd0);
    checkOutput("abort_hold_q", dif.quotient, 32'd0);

    applyStimulus(1'b0, 32'd9, 32'd3, lat);
    checkOutput("post_reset_latency", 32'(lat), 32'd33);
    checkOutput("post_reset_quotient", dif.quotient, 32'd3);
    checkOutput("post_reset_remainder", dif.remainder, 32'd0);
    checkOutput("post_reset_dbz", {31'd0, dif.division_by_zero}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
